// File: rtl/line_raster_sink.sv
// line_raster_sink: plots incoming {x,y} points into a square bitmap and
// streams the bitmap back out as bytes on request.
module line_raster_sink #(
  parameter int unsigned GRID_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     pt_valid,
  input  logic [2*GRID_BITS-1:0]   pt_xy,
  input  logic                     pt_last,
  output logic                     pt_ready,
  input  logic                     scan_start,
  output logic                     scan_valid,
  output logic [7:0]               scan_data,
  output logic                     scan_last,
  input  logic                     scan_ready,
  output logic                     busy,
  output logic [2*GRID_BITS:0]     pix_count,
  output logic [3:0]               line_cnt
);

  localparam int unsigned GRID   = 1 << GRID_BITS;
  localparam int unsigned NBYTES = (GRID * GRID) / 8;
  localparam int unsigned KW     = $clog2(NBYTES);
  localparam int unsigned HB     = GRID_BITS - 3;   // byte-within-row index bits
  localparam int unsigned PW     = 2 * GRID_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t                 state;
  logic [GRID-1:0]        bitmap [GRID];
  logic [GRID_BITS-1:0]   row;
  logic [KW-1:0]          k;
  logic [KW-1:0]          k_nxt;
  logic [GRID_BITS-1:0]   k_row;
  logic [HB+2:0]          k_base;
  logic [7:0]             byte_nxt;
  logic [GRID_BITS-1:0]   pt_x;
  logic [GRID_BITS-1:0]   pt_y;

  assign pt_x = pt_xy[2*GRID_BITS-1:GRID_BITS];
  assign pt_y = pt_xy[GRID_BITS-1:0];

  // Points are taken only when idle and no mode request is pending.
  assign pt_ready = (state == IDLE) && !clr && !scan_start;
  assign busy     = (state != IDLE);

  // Next byte to present: byte 0 when starting a scan, k+1 while scanning.
  assign k_nxt    = (state == SCAN) ? k + KW'(1) : '0;
  assign k_row    = k_nxt[KW-1:HB];
  assign k_base   = {k_nxt[HB-1:0], 3'b000};
  assign byte_nxt = bitmap[k_row][k_base +: 8];

  // Controller, bitmap storage, counters and registered scan outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      k          <= '0;
      pix_count  <= '0;
      line_cnt   <= '0;
      scan_valid <= 1'b0;
      scan_data  <= '0;
      scan_last  <= 1'b0;
      for (int r = 0; r < GRID; r++) begin
        bitmap[r] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state     <= CLEAR;
            row       <= '0;
            pix_count <= '0;
          end else if (scan_start) begin
            state      <= SCAN;
            k          <= '0;
            scan_valid <= 1'b1;
            scan_data  <= byte_nxt;
            scan_last  <= 1'b0;
          end else if (pt_valid && pt_ready) begin
            if (!bitmap[pt_y][pt_x]) begin
              pix_count <= pix_count + PW'(1);
            end
            bitmap[pt_y][pt_x] <= 1'b1;
            if (pt_last) begin
              line_cnt <= line_cnt + 4'd1;
            end
          end
        end

        CLEAR: begin
          bitmap[row] <= '0;
          row         <= row + GRID_BITS'(1);
          if (row == '1) begin
            state <= IDLE;
          end
        end

        SCAN: begin
          if (scan_ready) begin
            if (k == '1) begin
              state      <= IDLE;
              scan_valid <= 1'b0;
              scan_data  <= '0;
              scan_last  <= 1'b0;
            end else begin
              k         <= k_nxt;
              scan_data <= byte_nxt;
              scan_last <= (k_nxt == '1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_sink.sv
// Testbench for line_raster_sink: random and directed points checked against
// a plain 16x16 array model of the raster.
module tb_line_raster_sink;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       pt_valid;
  logic [7:0] pt_xy;
  logic       pt_last;
  logic       pt_ready;
  logic       scan_start;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       scan_last;
  logic       scan_ready;
  logic       busy;
  logic [8:0] pix_count;
  logic [3:0] line_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  bit bm [16][16];
  int m_line;

  line_raster_sink #(.GRID_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .pt_valid   (pt_valid),
    .pt_xy      (pt_xy),
    .pt_last    (pt_last),
    .pt_ready   (pt_ready),
    .scan_start (scan_start),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .scan_last  (scan_last),
    .scan_ready (scan_ready),
    .busy       (busy),
    .pix_count  (pix_count),
    .line_cnt   (line_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int m_pix();
    int c = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        c += int'(bm[y][x]);
    return c;
  endfunction

  function automatic logic [7:0] m_byte(input int kk);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = bm[kk / 2][8 * (kk % 2) + i];
    return b;
  endfunction

  task automatic model_clear();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        bm[y][x] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clr = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; pt_xy = 8'h00;
    scan_start = 1'b0; scan_ready = 1'b0;
    model_clear();
    m_line = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one point and hold it until accepted; reports wait and busy at accept.
  task automatic send_point(input logic [7:0] xy, input bit last, output int waited, output bit bsy);
    @(negedge clk);
    pt_valid = 1'b1; pt_xy = xy; pt_last = last;
    #1;
    waited = 0;
    while (!pt_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    bsy = busy;
    if (!pt_ready) check("pt_accept_timeout", 0, 1);
    else begin
      bm[xy[3:0]][xy[7:4]] = 1'b1;
      if (last) m_line = (m_line + 1) % 16;
    end
    @(negedge clk);
    pt_valid = 1'b0; pt_last = 1'b0;
  endtask

  // Read the whole bitmap; stall toggles scan_ready every cycle.
  task automatic do_scan(input bit stall, output int vcyc, output logic [7:0] bytes [32]);
    logic [7:0] exp [32];
    logic [7:0] prev_d;
    logic       prev_l;
    bit         prev_stall;
    bit         r;
    int         got;
    for (int i = 0; i < 32; i++) begin exp[i] = m_byte(i); bytes[i] = 8'h00; end
    got = 0; vcyc = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    @(negedge clk);
    scan_start = 1'b1; scan_ready = 1'b0;
    @(negedge clk);
    scan_start = 1'b0;
    check("scan_valid_first", scan_valid, 1);
    while (scan_valid && vcyc < 300) begin
      vcyc++;
      if (prev_stall) begin
        check("stall_hold_data", scan_data, prev_d);
        check("stall_hold_last", scan_last, prev_l);
      end
      r = stall ? (vcyc % 2 == 0) : 1'b1;
      scan_ready = r;
      if (r) begin
        if (got < 32) begin
          check($sformatf("scan_byte%0d", got), scan_data, exp[got]);
          check($sformatf("scan_last%0d", got), scan_last, (got == 31) ? 1 : 0);
          bytes[got] = scan_data;
        end else check("scan_extra_byte", got, 31);
        got++;
      end
      prev_stall = !r; prev_d = scan_data; prev_l = scan_last;
      @(negedge clk);
    end
    scan_ready = 1'b0;
    check("scan_handshakes", got, 32);
    check("scan_done_valid", scan_valid, 0);
    check("scan_done_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w, vc, n;
    bit         bs;
    logic [7:0] ba [32];
    logic [7:0] bb [32];

    rst_n = 1'b0; clr = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; pt_xy = 8'h00;
    scan_start = 1'b0; scan_ready = 1'b0; m_line = 0;
    model_clear();
    #12;
    check("rst_scan_valid", scan_valid, 0);
    check("rst_scan_data", scan_data, 0);
    check("rst_scan_last", scan_last, 0);
    check("rst_busy", busy, 0);
    check("rst_pix", pix_count, 0);
    check("rst_line", line_cnt, 0);
    do_reset();
    #1;
    check("rst_pt_ready", pt_ready, 1);

    // Diagonal
    send_point(8'h00, 1'b0, w, bs);
    send_point(8'h11, 1'b0, w, bs);
    send_point(8'h22, 1'b0, w, bs);
    send_point(8'h33, 1'b1, w, bs);
    check("diag_pix", pix_count, 4);
    check("diag_line", line_cnt, 1);
    do_scan(1'b0, vc, ba);
    check("diag_cycles", vc, 32);
    check("diag_b0", ba[0], 8'h01);
    check("diag_b2", ba[2], 8'h02);
    check("diag_b4", ba[4], 8'h04);
    check("diag_b6", ba[6], 8'h08);

    // Duplicates and corner
    do_reset();
    send_point(8'h9F, 1'b0, w, bs);
    send_point(8'h9F, 1'b0, w, bs);
    send_point(8'hFF, 1'b1, w, bs);
    check("dup_pix", pix_count, 2);
    do_scan(1'b0, vc, ba);
    check("corner_b31", ba[31], 8'h82);

    // Random points, unstalled then stalled scans of the same image
    for (int round = 0; round < 3; round++) begin
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++)
        send_point(8'($urandom), 1'($urandom), w, bs);
      check("rand_pix", pix_count, m_pix());
      check("rand_line", line_cnt, m_line);
      do_scan(1'b0, vc, ba);
      check("rand_cycles", vc, 32);
      do_scan(1'b1, vc, bb);
      check("stall_cycles", vc, 64);
      for (int i = 0; i < 32; i++)
        check($sformatf("stall_same%0d", i), bb[i], ba[i]);
    end

    // Clear and arbitration
    @(negedge clk);
    clr = 1'b1; scan_start = 1'b1; pt_valid = 1'b1; pt_xy = 8'h55; pt_last = 1'b1;
    #1;
    check("arb_pt_ready", pt_ready, 0);
    @(negedge clk);
    clr = 1'b0; scan_start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    check("clear_len", n, 16);
    model_clear();
    check("clear_pix", pix_count, 0);
    check("clear_line", line_cnt, m_line);
    do_scan(1'b0, vc, ba);

    // Wrap of line_cnt and point blocked by a scan
    do_reset();
    for (int i = 0; i < 17; i++) send_point(8'($urandom), 1'b1, w, bs);
    check("wrap_line", line_cnt, 1);
    check("wrap_pix", pix_count, m_pix());
    fork
      do_scan(1'b0, vc, ba);
      send_point(8'hA7, 1'b0, w, bs);
    join
    check("block_wait", w, 33);
    check("block_busy", bs, 0);
    check("block_pix", pix_count, m_pix());

    // Reset in the middle of a scan
    @(negedge clk);
    scan_start = 1'b1; scan_ready = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_valid_before", scan_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", scan_valid, 0);
    check("mid_pix", pix_count, 0);
    check("mid_line", line_cnt, 0);
    check("mid_busy", busy, 0);
    check("mid_data", scan_data, 0);
    model_clear();
    m_line = 0;
    @(negedge clk);
    rst_n = 1'b1; scan_ready = 1'b0;
    do_scan(1'b0, vc, ba);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
